i2c_pwm_cmd_bank: RTL and testbench

- Downstream consumer of the I2C slave register bank.
- Takes the SCL-domain write registers, moves them safely into the system clock domain on an explicit host commit, and drives NUM_CH servo/ESC-style PWM outputs.
- Enforces a commit watchdog that forces all channels to neutral, and returns status/echo bytes as the slave's read registers.

---
 rtl/i2c_pwm_cmd_bank_pkg.sv | 37 +++
 rtl/i2c_pwm_cmd_bank_pwm_channel.sv | 41 ++++
 rtl/i2c_pwm_cmd_bank.sv | 137 +++++++++++++
 tb/tb_i2c_pwm_cmd_bank.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pwm_cmd_bank_pkg.sv
// Shared types and constants for the I2C-commanded PWM bank.
package i2c_pwm_cmd_bank_pkg;

  typedef logic [7:0]  bus08_t;
  typedef logic [10:0] width_t;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RUN      = 2'd2,
    ST_TRIPPED  = 2'd3
  } pwm_state_e;

  localparam bus08_t NEUTRAL = 8'h7D;

  localparam int unsigned ENABLE_BIT     = 0;
  localparam int unsigned COMMIT_BIT     = 7;
  localparam int unsigned STAT_TRIP_BIT  = 0;
  localparam int unsigned STAT_STATE_LSB = 1;
  localparam int unsigned STAT_CNT_LSB   = 4;

  // 1000 us + 4 us per command step
  function automatic width_t cmd_to_width(input bus08_t v);
    return 11'd1000 + width_t'({v, 2'b00});
  endfunction

  function automatic bus08_t pack_status(input logic [3:0] cnt, input pwm_state_e st,
                                         input logic trip);
    bus08_t s;
    s = '0;
    s[STAT_CNT_LSB +: 4]   = cnt;
    s[STAT_STATE_LSB +: 2] = st;
    s[STAT_TRIP_BIT]       = trip;
    return s;
  endfunction

endpackage

// File: rtl/i2c_pwm_cmd_bank_pwm_channel.sv
// One PWM channel: latches its command at frame start and compares against the frame counter.
module i2c_pwm_cmd_bank_pwm_channel
  import i2c_pwm_cmd_bank_pkg::*;
#(
  parameter int unsigned CNT_W = 15
) (
  input  logic             clk,
  input  logic             startRst,
  input  logic             frame_start_i,
  input  logic [CNT_W-1:0] frame_cnt_i,
  input  logic             run_i,
  input  bus08_t           cmd_i,
  output logic             pwm_o,
  output bus08_t           active_o
);

  bus08_t active_q, active_d;
  width_t width_c;
  logic   pwm_q, pwm_d;

  // Use the incoming command on the frame-start cycle so the new width covers tick 0 too
  always_comb begin
    active_d = frame_start_i ? cmd_i : active_q;
    width_c  = cmd_to_width(active_d);
    pwm_d    = run_i && (32'(frame_cnt_i) < 32'(width_c));
  end

  always_ff @(posedge clk or posedge startRst) begin
    if (startRst) begin
      active_q <= NEUTRAL;
      pwm_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o    = pwm_q;
  assign active_o = active_q;

endmodule

// File: rtl/i2c_pwm_cmd_bank.sv
// Moves I2C write registers into the clk domain on host commit and drives watchdog-guarded PWM.
module i2c_pwm_cmd_bank
  import i2c_pwm_cmd_bank_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned PRESCALE    = 100,
  parameter int unsigned FRAME_TICKS = 20000,
  parameter int unsigned WDOG_FRAMES = 25
) (
  input  logic                clk,
  input  logic                startRst,
  input  bus08_t [NUM_CH:0]   wr_regs,
  output bus08_t [NUM_CH:0]   rd_regs,
  output logic   [NUM_CH-1:0] pwm_out,
  output logic                wdog_trip
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned FC_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned WD_W = $clog2(WDOG_FRAMES + 1);

  logic en_s1_q, en_s2_q, cm_s1_q, cm_s2_q, cm_s3_q;
  logic [1:0] prime_q, settle_q;
  logic [PS_W-1:0] presc_q;
  logic [FC_W-1:0] frame_cnt_q;
  logic frame_start_q;
  pwm_state_e state_q, state_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic trip_q, trip_d;
  logic [3:0] cnt_q, cnt_d;
  bus08_t [NUM_CH-1:0] shadow_q, shadow_d, cmd_c, echo_c;
  bus08_t status_q;
  logic tick_c, wrap_c, commit_evt_c, capture_c, run_c;
  logic unused_ctrl_c;

  assign unused_ctrl_c = ^wr_regs[NUM_CH][6:1];

  assign tick_c       = (presc_q == PS_W'(PRESCALE - 1));
  assign wrap_c       = tick_c && (frame_cnt_q == FC_W'(FRAME_TICKS - 1));
  // Edges are ignored until the commit synchronizer has filled after reset
  assign commit_evt_c = (cm_s2_q ^ cm_s3_q) && (prime_q == 2'd3);
  assign capture_c    = (settle_q == 2'd1);
  assign run_c        = (state_d != ST_DISABLED);

  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    case (state_q)
      ST_DISABLED: if (en_s2_q) state_d = ST_ARMED;
      ST_ARMED: if (capture_c) begin
        state_d = ST_RUN;
        wdog_d  = '0;
      end
      ST_RUN: begin
        if (capture_c) begin
          wdog_d = '0;
        end else if (frame_start_q) begin
          wdog_d = wdog_q + WD_W'(1);
          if (wdog_d == WD_W'(WDOG_FRAMES)) state_d = ST_TRIPPED;
        end
      end
      ST_TRIPPED: if (capture_c) begin
        state_d = ST_RUN;
        wdog_d  = '0;
      end
    endcase
    if (!en_s2_q) begin
      state_d = ST_DISABLED;
      wdog_d  = '0;
    end
    shadow_d = capture_c ? wr_regs[NUM_CH-1:0] : shadow_q;
    cnt_d    = capture_c ? cnt_q + 4'd1 : cnt_q;
    trip_d   = (state_d == ST_TRIPPED);
    for (int c = 0; c < NUM_CH; c++) begin
      cmd_c[c] = (state_d == ST_RUN) ? shadow_d[c] : NEUTRAL;
    end
  end

  always_ff @(posedge clk or posedge startRst) begin
    if (startRst) begin
      en_s1_q       <= 1'b0;
      en_s2_q       <= 1'b0;
      cm_s1_q       <= 1'b0;
      cm_s2_q       <= 1'b0;
      cm_s3_q       <= 1'b0;
      prime_q       <= '0;
      settle_q      <= '0;
      presc_q       <= '0;
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b1;
      state_q       <= ST_DISABLED;
      wdog_q        <= '0;
      trip_q        <= 1'b0;
      cnt_q         <= '0;
      shadow_q      <= {NUM_CH{NEUTRAL}};
      status_q      <= '0;
    end else begin
      en_s1_q  <= wr_regs[NUM_CH][ENABLE_BIT];
      en_s2_q  <= en_s1_q;
      cm_s1_q  <= wr_regs[NUM_CH][COMMIT_BIT];
      cm_s2_q  <= cm_s1_q;
      cm_s3_q  <= cm_s2_q;
      if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
      // Channel bytes are sampled two cycles after the commit edge
      if (commit_evt_c)          settle_q <= 2'd2;
      else if (settle_q != 2'd0) settle_q <= settle_q - 2'd1;
      presc_q <= tick_c ? '0 : presc_q + PS_W'(1);
      if (tick_c) frame_cnt_q <= wrap_c ? '0 : frame_cnt_q + FC_W'(1);
      frame_start_q <= wrap_c;
      state_q  <= state_d;
      wdog_q   <= wdog_d;
      trip_q   <= trip_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      if (frame_start_q || capture_c) status_q <= pack_status(cnt_d, state_d, trip_d);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    i2c_pwm_cmd_bank_pwm_channel #(
      .CNT_W(FC_W)
    ) u_ch (
      .clk          (clk),
      .startRst     (startRst),
      .frame_start_i(frame_start_q),
      .frame_cnt_i  (frame_cnt_q),
      .run_i        (run_c),
      .cmd_i        (cmd_c[c]),
      .pwm_o        (pwm_out[c]),
      .active_o     (echo_c[c])
    );
  end

  assign rd_regs   = {status_q, echo_c};
  assign wdog_trip = trip_q;

endmodule

// File: tb/tb_i2c_pwm_cmd_bank.sv
// Directed/randomized bench for i2c_pwm_cmd_bank with a frame-level reference model.
module tb_i2c_pwm_cmd_bank;
  import i2c_pwm_cmd_bank_pkg::*;

  localparam int unsigned NCH       = 4;
  localparam int unsigned PS        = 2;
  localparam int unsigned FT        = 2040;
  localparam int unsigned WD        = 3;
  localparam int          FRAME_CYC = PS * FT;
  localparam int          WIN       = FRAME_CYC - 30;

  logic clk = 1'b0;
  logic startRst;
  bus08_t [NCH:0] wr_regs;
  bus08_t [NCH:0] rd_regs;
  logic [NCH-1:0] pwm_out;
  logic wdog_trip;

  always #5 clk = ~clk;

  i2c_pwm_cmd_bank #(
    .NUM_CH(NCH), .PRESCALE(PS), .FRAME_TICKS(FT), .WDOG_FRAMES(WD)
  ) dut (
    .clk(clk), .startRst(startRst), .wr_regs(wr_regs),
    .rd_regs(rd_regs), .pwm_out(pwm_out), .wdog_trip(wdog_trip)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: 0=disabled 1=armed 2=run 3=tripped
  int m_state, m_wdog, m_cnt;
  logic [7:0] m_shadow[NCH];
  logic [7:0] pend[NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [7:0] s;
    s = {4'(m_cnt), 1'b0, 2'(m_state), (m_state == 3)};
    return 32'(s);
  endfunction

  function automatic logic [31:0] exp_cycles(input logic [7:0] v);
    return 32'((1000 + 4 * int'(v)) * PS);
  endfunction

  task automatic m_reset();
    m_state = 0; m_wdog = 0; m_cnt = 0;
    for (int c = 0; c < NCH; c++) m_shadow[c] = NEUTRAL;
  endtask

  task automatic m_frame();
    if (m_state == 2) begin
      m_wdog++;
      if (m_wdog >= int'(WD)) m_state = 3;
    end
  endtask

  task automatic m_commit();
    for (int c = 0; c < NCH; c++) m_shadow[c] = pend[c];
    m_cnt = (m_cnt + 1) % 16;
    if (m_state != 0) begin
      m_state = 2;
      m_wdog  = 0;
    end
  endtask

  task automatic rand_pend();
    for (int c = 0; c < NCH; c++) pend[c] = 8'($urandom);
  endtask

  task automatic sync_rise();
    logic prev;
    bit ok;
    ok   = 1'b0;
    prev = pwm_out[0];
    for (int i = 0; i < 2 * FRAME_CYC; i++) begin
      @(negedge clk);
      if (!prev && pwm_out[0]) begin
        ok = 1'b1;
        break;
      end
      prev = pwm_out[0];
    end
    chk("frame_sync", 32'(ok), 32'd1);
  endtask

  // Measure one full frame; optionally write pend[] and toggle commit mid-pulse
  task automatic measure(input bit do_commit, input string tag);
    int hi[NCH];
    logic [7:0] e[NCH];
    sync_rise();
    m_frame();
    for (int c = 0; c < NCH; c++) begin
      e[c]  = (m_state == 2) ? m_shadow[c] : NEUTRAL;
      hi[c] = 0;
    end
    for (int i = 0; i < WIN; i++) begin
      if (i > 0) @(negedge clk);
      for (int c = 0; c < NCH; c++) if (pwm_out[c]) hi[c]++;
      if (do_commit && i == 500) for (int c = 0; c < NCH; c++) wr_regs[c] = pend[c];
      if (do_commit && i == 520) begin
        wr_regs[NCH][7] = ~wr_regs[NCH][7];
        m_commit();
      end
    end
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("%s width ch%0d", tag, c), 32'(hi[c]), exp_cycles(e[c]));
      chk($sformatf("%s echo ch%0d", tag, c), 32'(rd_regs[c]), 32'(e[c]));
    end
    chk($sformatf("%s status", tag), 32'(rd_regs[NCH]), m_status());
    chk($sformatf("%s wdog_trip", tag), 32'(wdog_trip), 32'(m_state == 3));
  endtask

  task automatic check_low(input int n, input string tag);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pwm_out != '0) hits++;
    end
    chk(tag, 32'(hits), 32'd0);
  endtask

  initial begin
    startRst = 1'b1;
    wr_regs  = '0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("reset pwm", 32'(pwm_out), 32'd0);
    chk("reset trip", 32'(wdog_trip), 32'd0);
    chk("reset status", 32'(rd_regs[NCH]), 32'h00);
    for (int c = 0; c < NCH; c++) chk($sformatf("reset echo ch%0d", c), 32'(rd_regs[c]), 32'h7D);
    startRst = 1'b0;

    check_low(WIN, "disabled low");
    chk("disabled status", 32'(rd_regs[NCH]), 32'h00);

    wr_regs[NCH][0] = 1'b1;
    m_state = 1;
    repeat (FRAME_CYC + 20) @(negedge clk);
    measure(1'b0, "armed");

    pend[0] = 8'h00; pend[1] = 8'h7D; pend[2] = 8'hFF; pend[3] = 8'h40;
    measure(1'b1, "commit1");
    measure(1'b0, "plan widths");
    chk("plan status", 32'(rd_regs[NCH]), 32'h14);

    rand_pend();
    measure(1'b1, "rand commit");
    measure(1'b0, "rand widths");
    measure(1'b0, "wdog count");
    measure(1'b0, "wdog trip");

    for (int c = 0; c < NCH; c++) pend[c] = m_shadow[c];
    measure(1'b1, "recover");
    measure(1'b0, "restored");

    // Drop enable mid-pulse, then commit while disabled
    sync_rise();
    m_frame();
    repeat (500) @(negedge clk);
    chk("pre-disable high", 32'(pwm_out), 32'hF);
    wr_regs[NCH][0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("disable low", 32'(pwm_out), 32'd0);
    m_state = 0;
    m_wdog  = 0;
    rand_pend();
    for (int c = 0; c < NCH; c++) wr_regs[c] = pend[c];
    repeat (20) @(negedge clk);
    wr_regs[NCH][7] = ~wr_regs[NCH][7];
    m_commit();
    check_low(WIN + 100, "disabled commit low");
    chk("disabled commit status", 32'(rd_regs[NCH]), m_status());
    chk("disabled trip", 32'(wdog_trip), 32'd0);
    for (int c = 0; c < NCH; c++) chk($sformatf("disabled echo ch%0d", c), 32'(rd_regs[c]), 32'h7D);

    wr_regs[NCH][0] = 1'b1;
    m_state = 1;
    repeat (FRAME_CYC + 20) @(negedge clk);
    rand_pend();
    measure(1'b1, "rearm commit");
    measure(1'b0, "rearm widths");

    // Asynchronous reset mid-pulse with the commit bit held high
    sync_rise();
    repeat (300) @(negedge clk);
    #2 startRst = 1'b1;
    #1;
    chk("async reset pwm", 32'(pwm_out), 32'd0);
    chk("async reset status", 32'(rd_regs[NCH]), 32'h00);
    chk("async reset echo", 32'(rd_regs[2]), 32'h7D);
    wr_regs[NCH][7] = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    startRst = 1'b0;
    m_state = 1;
    repeat (100) @(negedge clk);
    measure(1'b0, "post reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
